// File: rtl/multiplexer_8x1_if.sv
// Bus between a lane producer and the registered 8-to-1 multiplexer.
//   en        capture enable
//   s         lane select, 0..7
//   in        eight packed lanes, lane k = in[k*WIDTH +: WIDTH], lane 0 in the LSBs
//   out       registered selected lane
//   out_valid high for the cycle after an enabled capture
// master: drives en/s/in and receives out/out_valid; slave: the multiplexer.
interface multiplexer_8x1_if #(
    parameter int unsigned WIDTH = 1
);
    localparam int unsigned LANES = 8;
    localparam int unsigned SEL_W = 3;

    logic                   en;
    logic [SEL_W-1:0]       s;
    logic [LANES*WIDTH-1:0] in;
    logic [WIDTH-1:0]       out;
    logic                   out_valid;

    modport master (
        output en,
        output s,
        output in,
        input  out,
        input  out_valid
    );

    modport slave (
        input  en,
        input  s,
        input  in,
        output out,
        output out_valid
    );
endinterface

// File: rtl/multiplexer_8x1.sv
// Registered 8-to-1 multiplexer: the 3-bit select picks one of eight
// WIDTH-bit lanes of the packed input bus and the lane is captured into an
// output register on an enabled clock edge.
//   clk    system clock, rising-edge active
//   rst_n  asynchronous active-low reset; clears out and out_valid at once
//   bus    slave side of multiplexer_8x1_if (en, s, in -> out, out_valid)
// WIDTH must match the WIDTH of the connected interface instance.
module multiplexer_8x1 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multiplexer_8x1_if.slave     bus
);
    localparam int unsigned LANES = 8;

    logic [WIDTH-1:0] lanes [LANES];
    logic [WIDTH-1:0] lane_c;
    logic [WIDTH-1:0] out_q;
    logic             out_valid_q;

    // Unpack the flat bus into lanes so the select indexes an array directly.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lanes[k] = bus.in[k*WIDTH +: WIDTH];
    end

    // Lane chosen by the current select.
    always_comb begin
        lane_c = lanes[bus.s];
    end

    // Output register; out holds its value on cycles without a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.en;
            if (bus.en) begin
                out_q <= lane_c;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_multiplexer_8x1.sv
// Self-checking bench for multiplexer_8x1 with WIDTH=1 and WIDTH=4 instances.
// Expected lanes are queued when stimulus is driven and popped when the
// registered output appears one clock later.
module tb_multiplexer_8x1;
    logic clk;
    logic rst_n;

    multiplexer_8x1_if #(.WIDTH(1)) bus1 ();
    multiplexer_8x1_if #(.WIDTH(4)) bus4 ();

    multiplexer_8x1 #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    multiplexer_8x1 #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [0:0] q1[$];
    logic [3:0] q4[$];
    logic [0:0] last1 = 1'b0;
    logic [3:0] last4 = 4'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // One clock on the WIDTH=1 instance; called just after a rising edge.
    task automatic drive1(input string tag, input logic e, input logic [2:0] sel,
                          input logic [7:0] data, input logic exp);
        logic [0:0] want;
        bus1.en = e;
        bus1.s  = sel;
        bus1.in = data;
        if (e) q1.push_back(exp);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(bus1.out_valid), 32'(e));
        if (e) begin
            if (q1.size() == 0) begin
                check({tag, "_underflow"}, 32'd1, 32'd0);
            end else begin
                want  = q1.pop_front();
                last1 = want;
                check(tag, 32'(bus1.out), 32'(want));
            end
        end else begin
            check({tag, "_hold"}, 32'(bus1.out), 32'(last1));
        end
    endtask

    // One clock on the WIDTH=4 instance; called just after a rising edge.
    task automatic drive4(input string tag, input logic e, input logic [2:0] sel,
                          input logic [31:0] data, input logic [3:0] exp);
        logic [3:0] want;
        bus4.en = e;
        bus4.s  = sel;
        bus4.in = data;
        if (e) q4.push_back(exp);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(bus4.out_valid), 32'(e));
        if (e) begin
            if (q4.size() == 0) begin
                check({tag, "_underflow"}, 32'd1, 32'd0);
            end else begin
                want  = q4.pop_front();
                last4 = want;
                check(tag, 32'(bus4.out), 32'(want));
            end
        end else begin
            check({tag, "_hold"}, 32'(bus4.out), 32'(last4));
        end
    endtask

    initial begin
        logic [2:0]  sel;
        logic [7:0]  data;
        logic [31:0] wdata;
        logic        e;
        logic        bor;

        rst_n   = 1'b0;
        bus1.en = 1'b0; bus1.s = 3'd0; bus1.in = 8'h00;
        bus4.en = 1'b0; bus4.s = 3'd0; bus4.in = 32'h0;
        #1;
        check("rst_out1",   32'(bus1.out),       32'd0);
        check("rst_valid1", 32'(bus1.out_valid), 32'd0);
        check("rst_out4",   32'(bus4.out),       32'd0);
        #22 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-subtractor difference: XOR of the select bits.
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            drive1("diff", 1'b1, sel, 8'b10010110, ^sel);
        end

        // Reset mid-cycle while out=1 must clear at once and hold with en=1.
        check("pre_rst_out", 32'(bus1.out), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_out",   32'(bus1.out),       32'd0);
        check("async_rst_valid", 32'(bus1.out_valid), 32'd0);
        bus1.en = 1'b1; bus1.s = 3'd7; bus1.in = 8'hFF;
        bus4.en = 1'b1; bus4.s = 3'd7; bus4.in = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_out1",   32'(bus1.out),       32'd0);
            check("rst_hold_valid1", 32'(bus1.out_valid), 32'd0);
            check("rst_hold_out4",   32'(bus4.out),       32'd0);
        end
        bus1.en = 1'b0;
        bus4.en = 1'b0;
        last1   = 1'b0;
        last4   = 4'h0;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(bus1.out_valid), 32'd0);

        // Full-subtractor borrow with s = {A, B, Bin}.
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            bor = (~sel[2] & sel[1]) | (~sel[2] & sel[0]) | (sel[1] & sel[0]);
            drive1("borrow", 1'b1, sel, 8'b10001110, bor);
        end

        // Hold: inputs changing with en=0 must not disturb out.
        drive1("hold_cap", 1'b1, 3'd1, 8'b10010110, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive1("hold", 1'b0, 3'd0, 8'h00, 1'b0);
        end

        // Walking one, then walking zero.
        for (int i = 0; i < 8; i++) begin
            sel  = 3'(i);
            data = 8'h01 << i;
            drive1("walk1", 1'b1, sel, data, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            sel  = 3'(i);
            data = ~(8'h01 << i);
            drive1("walk0", 1'b1, sel, data, 1'b0);
        end

        // Wide lanes: each lane holds its own index.
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            drive4("wide", 1'b1, sel, 32'h7654_3210, 4'(i));
        end
        drive4("wide_idle", 1'b0, 3'd0, 32'hFFFF_FFFF, 4'h0);

        // Random traffic with random enables on both widths.
        for (int i = 0; i < 40; i++) begin
            e    = 1'($urandom_range(0, 1));
            sel  = 3'($urandom_range(0, 7));
            data = 8'($urandom);
            drive1("rand1", e, sel, data, data[sel]);
        end
        for (int i = 0; i < 40; i++) begin
            e     = 1'($urandom_range(0, 1));
            sel   = 3'($urandom_range(0, 7));
            wdata = $urandom;
            drive4("rand4", e, sel, wdata, 4'(wdata >> (4 * int'(sel))));
        end

        check("q1_empty", 32'(q1.size()), 32'd0);
        check("q4_empty", 32'(q4.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
